aud_player: RTL
===============

# aud_player

I2S transmit serializer for the WM8731 DAC path, the playback counterpart of the recorder on the ADC path. It takes one 16-bit mono sample per audio frame from the playback datapath (SRAM reader / rate controller) and shifts it MSB-first onto DACDAT in both the left and right slots, framed by the codec-generated DACLRCK. It pulses a tick when it consumes a sample so the upstream address counter can advance, and it sends zeros when paused or starved.

## Interface
- DATA_W, 16: sample width and number of bits shifted per slot.
- CNT_W, 5: slot bit-counter width; must satisfy 2^CNT_W > DATA_W.
- i_clk  in  1  bit clock. Top level supplies inverted BCLK, so DACDAT changes on BCLK falling edges.
- i_rst_n  in  1  asynchronous active-low reset.
- i_lrc  in  1  DACLRCK from codec; low = left slot, high = right slot.
- i_en  in  1  play enable; sampled only at left-slot start.
- i_valid  in  1  i_data holds a sample available for consumption.
- i_data  in  DATA_W  signed two's-complement sample.
- o_aud_dacdat  out  1  serial data to codec.
- o_sample_tick  out  1  one-cycle pulse: i_data consumed this cycle.
- o_underrun  out  1  one-cycle pulse: i_en high but i_valid low at left-slot start.
- o_active  out  1  high while the current frame carries a real sample.

## Operation
- lrc_q: i_lrc registered each cycle; reset value 0. fall = lrc_q & ~i_lrc, rise = ~lrc_q & i_lrc.
- States: S_SYNC, S_SEND, S_PAD. Registers: shift_r[DATA_W], samp_r[DATA_W], cnt_r[CNT_W], ch_r.
- S_SYNC (reset state): ignore rise; on fall, run the left-slot start below and go to S_SEND. Because lrc_q resets to 0, a fall requires i_lrc to have been seen high after reset.
- Left-slot start (fall):
  - If i_en & i_valid: samp_r <= i_data, o_sample_tick = 1, o_active <= 1.
  - Else: samp_r <= 0, o_active <= 0. o_underrun = i_en & ~i_valid.
  - Shift the new samp_r value out: o_aud_dacdat <= bit DATA_W-1, cnt_r <= 1, ch_r <= 0.
- Right-slot start (rise) in S_SEND or S_PAD: reload from the held samp_r (no tick, no new sample), o_aud_dacdat <= samp_r[DATA_W-1], cnt_r <= 1, ch_r <= 1, go to S_SEND.
- S_SEND without an edge:
  - o_aud_dacdat <= next bit, MSB to LSB; cnt_r increments.
  - After the LSB is driven (cnt_r == DATA_W), go to S_PAD and drive 0.
- S_PAD: drive 0 until the next edge. A fall or rise restarts per the rules above.
- An LRC edge in S_SEND before the LSB (short slot) aborts the remaining bits and starts the new slot immediately.
- i_en low mid-frame has no effect until the next fall; that frame's right slot still carries samp_r.
- Reset mid-operation: all registers clear asynchronously and the block returns to S_SYNC. Output resumes only after a fresh high-to-low LRC sequence.

## Timing
- Reset values: o_aud_dacdat 0, o_sample_tick 0, o_underrun 0, o_active 0, state S_SYNC, all counters and shift registers 0.
- Edge detect happens on the first i_clk edge at which i_lrc shows its new level. The MSB is registered on that same edge, so it is valid during the 2nd BCLK period after the LRC transition (I2S one-bit delay).
- Slot data occupies exactly DATA_W consecutive cycles, followed by zeros.
- o_sample_tick and o_underrun are combinational from the fall detect and last one cycle. Upstream must hold i_data stable while i_valid is high until it sees the tick.
- At most one tick per frame.

## Structure
- Shared package aud_pkg:
  - state enum (S_SYNC, S_SEND, S_PAD);
  - AUD_DATA_W = 16 constant, also used by the recorder;
  - channel constants CH_LEFT = 0, CH_RIGHT = 1.
- One sub-module, aud_lrc_edge: LRC register plus fall/rise detect. Reusable by the recorder.
- The remainder is a single FSM with a shift register in aud_player.

## Test plan
- LRC period 64 clocks (32 low / 32 high), i_en = 1, i_valid = 1, i_data = 16'hCAA6:
  - left slot shows 1100_1010_1010_0110 starting 1 cycle after the fall, then 16 zeros;
  - right slot is identical;
  - exactly one o_sample_tick, at the fall cycle.
- i_en = 0 across two frames with i_valid = 1: DACDAT all zero, no tick, no underrun, o_active = 0.
- i_en = 1, i_valid = 0 at the fall: one o_underrun pulse, zero frame. Raise i_valid with 16'h8001 before the next fall: that frame sends 1000_0000_0000_0001 in both slots.
- Short slot: LRC high after 10 low cycles. Left slot is truncated after 10 bits, and the right slot sends the full 16 bits from the MSB.
- Assert i_rst_n low mid-slot: outputs 0 immediately. Release with i_lrc low: no output and no tick until i_lrc goes high then low.
- Back-to-back frames with samples 16'h7FFF, 16'h8000, 16'h0000: correct bits per frame and one tick per frame.

Source files
------------

// File: rtl/aud_pkg.sv
// aud_pkg: shared types and constants for the WM8731 audio playback and record paths
package aud_pkg;
   typedef enum logic [1:0] {S_SYNC, S_SEND, S_PAD} aud_state_e;
   localparam int   AUD_DATA_W = 16;
   localparam logic CH_LEFT    = 1'b0;
   localparam logic CH_RIGHT   = 1'b1;
endpackage

// File: rtl/aud_lrc_edge.sv
// aud_lrc_edge: registers LRC and flags its falling (left-slot) and rising (right-slot) edges
module aud_lrc_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_lrc,
   output logic o_fall,
   output logic o_rise
);
   logic lrc_q;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) lrc_q <= 1'b0;
      else lrc_q <= i_lrc;
   assign o_fall = lrc_q & ~i_lrc;
   assign o_rise = ~lrc_q & i_lrc;
endmodule

// File: rtl/aud_player.sv
// aud_player: I2S transmit serializer, one mono sample per frame sent MSB-first in both slots
module aud_player
   import aud_pkg::*;
#(
   parameter int DATA_W = AUD_DATA_W,
   parameter int CNT_W  = 5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_lrc,
   input  logic              i_en,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_aud_dacdat,
   output logic              o_sample_tick,
   output logic              o_underrun,
   output logic              o_active
);
   aud_state_e        state_r, state_n;
   logic [DATA_W-1:0] shift_r, samp_r, samp_n;
   logic [CNT_W-1:0]  cnt_r;
   logic              ch_r, fall, rise, take, start_r, last;

   aud_lrc_edge u_edge (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_lrc   (i_lrc),
      .o_fall  (fall),
      .o_rise  (rise)
   );

   // a right slot only follows a left slot of the same frame
   assign start_r = rise & (state_r != S_SYNC) & (ch_r == CH_LEFT);
   assign take    = fall & i_en & i_valid;
   assign last    = cnt_r == CNT_W'(DATA_W);
   assign samp_n  = take ? i_data : '0;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) state_r <= S_SYNC;
      else state_r <= state_n;

   always_comb begin
      state_n = state_r;
      if (fall || start_r) state_n = S_SEND;
      else if (state_r == S_SEND && last) state_n = S_PAD;
   end

   always_comb begin
      o_sample_tick = take;
      o_underrun    = fall & i_en & ~i_valid;
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         shift_r      <= '0;
         samp_r       <= '0;
         cnt_r        <= '0;
         ch_r         <= CH_LEFT;
         o_aud_dacdat <= 1'b0;
         o_active     <= 1'b0;
      end else if (fall) begin
         samp_r       <= samp_n;
         shift_r      <= samp_n << 1;
         o_aud_dacdat <= samp_n[DATA_W-1];
         cnt_r        <= CNT_W'(1);
         ch_r         <= CH_LEFT;
         o_active     <= take;
      end else if (start_r) begin
         shift_r      <= samp_r << 1;
         o_aud_dacdat <= samp_r[DATA_W-1];
         cnt_r        <= CNT_W'(1);
         ch_r         <= CH_RIGHT;
      end else if (state_r == S_SEND && !last) begin
         shift_r      <= shift_r << 1;
         o_aud_dacdat <= shift_r[DATA_W-1];
         cnt_r        <= cnt_r + CNT_W'(1);
      end else begin
         o_aud_dacdat <= 1'b0;
      end
endmodule
